// File: rtl/tpum_apb_pkg.sv
// Shared definitions for the TPUM APB initiator: bus widths, FSM state encoding
// and the TPUM register map used by the host-side sequencer.
package tpum_apb_pkg;

  localparam int unsigned APB_ADDR_W = 9;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // TPUM register indices; the APB byte address is the index shifted left by two.
  localparam int unsigned REG_DIM_A_VER  = 0;
  localparam int unsigned REG_DIM_B_VER  = 1;
  localparam int unsigned REG_TPUM_MODE  = 5;
  localparam int unsigned REG_TPUM_START = 6;
  localparam int unsigned REG_STATUS     = 11;
  localparam int unsigned REG_RESULT     = 12;

  localparam logic [2:0] MODE_BNN_OP = 3'b010;

  function automatic logic [APB_ADDR_W-1:0] reg_addr(input int unsigned idx);
    return APB_ADDR_W'(idx << 2);
  endfunction

endpackage

// File: rtl/tpum_apb_master.sv
// Single-outstanding APB3 initiator turning a valid/ready command stream into
// TPUM register transfers. Define TPUM_APB_TIMEOUT_EN to build the ACCESS timeout.
module tpum_apb_master
  import tpum_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  logic [1:0] state;
  logic       timeout_hit;

  // NOTE: every register here is updated with <= so all flops sample the same
  // pre-edge values; blocking assignments would make the result order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // The APB address/data registers double as the command latch.
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            state     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TPUM_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_flag;

  // A pready in the expiry cycle takes precedence, so expiry requires pready low.
  assign timeout_hit = (state == S_ACCESS) && !pready && (to_cnt == CNT_LAST);
  assign rsp_timeout = to_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == S_SETUP) begin
        to_cnt <= '0;
      end else if ((state == S_ACCESS) && !pready && !timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout_hit) begin
        to_flag <= 1'b1;
      end else if ((state == S_RESP) && rsp_ready) begin
        to_flag <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule
